// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser; clk/rst in, tx_start+tx_data request in, tx line, tx_busy and one-cycle tx_done out
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sr, sr_n;
  logic tx_n, busy_n, done_n, wrap;
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n   = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
    idx_n   = idx;
    sr_n    = sr;
    tx_n    = tx;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    case (state)
      IDLE: if (tx_start) begin
        state_n = START;
        tx_n    = 1'b0;
        busy_n  = 1'b1;
        sr_n    = tx_data;
        idx_n   = '0;
      end
      START: if (wrap) begin
        state_n = DATA;
        tx_n    = sr[0];
      end
      DATA: if (wrap) begin
        state_n = (idx == 3'd7) ? STOP : DATA;
        tx_n    = (idx == 3'd7) ? 1'b1 : sr[1];
        sr_n    = (idx == 3'd7) ? sr : sr >> 1;
        idx_n   = (idx == 3'd7) ? idx : idx + 3'd1;
      end
      STOP: if (wrap) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sr      <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sr      <= sr_n;
      tx      <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench with a behavioural line receiver checking uart_tx frames, flags and timing
module tb_uart_tx;
  localparam int N = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx, tx_busy, tx_done;
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, aborts = 0;
  int last_start = 0, prev_start = 0, last_done = 0, prev_done = 0;
  bit in_frame = 0;
  logic [7:0] sb[$];
  uart_tx #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    sb.push_back(b);
    tx_data = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask
  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      tick();
      n++;
    end
    chk(nm, done_cnt, target);
  endtask
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] rx, exp_b;
    int bad;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (tx) begin
        chk("idle_flags", {tx_busy, tx_done}, 0);
        continue;
      end
      in_frame = 1;
      prev_start = last_start;
      last_start = cyc;
      exp_b = 8'h00;
      if (sb.size() == 0) chk("unexpected_frame", 1, 0);
      else exp_b = sb.pop_front();
      bits = {1'b1, exp_b, 1'b0};
      bad = 0;
      ab = 0;
      rx = '0;
      for (int c = 0; c < 10 * N; c++) begin
        if (c > 0) @(negedge clk);
        if (rst) begin
          ab = 1;
          break;
        end
        if (tx !== bits[c / N] || tx_busy !== 1'b1 || tx_done !== 1'b0) bad++;
        if (c % N == N / 2 && c / N >= 1 && c / N <= 8) rx = {tx, rx[7:1]};
      end
      if (ab) aborts++;
      else begin
        chk("frame_shape_errors", bad, 0);
        chk("rx_byte", rx, exp_b);
        @(negedge clk);
        if (!rst) begin
          chk("done_pulse_tx_busy_done", {tx, tx_busy, tx_done}, 3'b101);
          prev_done = last_done;
          last_done = cyc;
          done_cnt++;
        end
      end
      in_frame = 0;
    end
  end
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin : stim
    int exp_done = 0;
    tx_start = 1'b1;
    tx_data = 8'h55;
    repeat (3) begin
      tick();
      chk("rst_outputs", {tx, tx_busy, tx_done}, 3'b100);
    end
    rst = 1'b0;
    tx_start = 1'b0;
    repeat (5) tick();
    chk("rst_no_frame", {tx, tx_busy, in_frame}, 3'b100);
    send(8'hA5);
    repeat (39) tick();
    tx_data = 8'h3C;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (14) tick();
    tx_data = 8'hE7;
    exp_done++;
    wait_done(exp_done, "single_byte_done");
    repeat (20) tick();
    chk("single_one_done_only", done_cnt, exp_done);
    chk("single_queue_empty", sb.size(), 0);
    sb.push_back(8'h00);
    tx_data = 8'h00;
    tx_start = 1'b1;
    tick();
    sb.push_back(8'hFF);
    tx_data = 8'hFF;
    repeat (101) tick();
    tx_start = 1'b0;
    exp_done += 2;
    wait_done(exp_done, "b2b_done");
    chk("b2b_start_gap", last_start - prev_start, 101);
    chk("b2b_done_gap", last_done - prev_done, 101);
    repeat (5) tick();
    send(8'h81);
    repeat (44) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_outputs", {tx, tx_busy, tx_done}, 3'b100);
    repeat (120) tick();
    chk("midrst_aborts", aborts, 1);
    chk("midrst_no_done", done_cnt, exp_done);
    send(8'h81);
    exp_done++;
    wait_done(exp_done, "after_rst_done");
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(8'($urandom));
      exp_done++;
      wait_done(exp_done, "loopback_done");
    end
    repeat (5) tick();
    chk("final_queue_empty", sb.size(), 0);
    chk("final_done_count", done_cnt, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
